// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the monitor UART transmit scheduler.
// Rev 1.0 - initial release.
`default_nettype none
`timescale 1ns/1ps

package uart_pkg;

    localparam int UART_DATA_W = 8;
    localparam int CLK_HZ      = 50_000_000;
    localparam int BAUD_RATE   = 115200;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_STOP   = 3'd4,
        ST_PARITY = 3'd5
    } uart_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_rr_arbiter.sv
// uart_rr_arbiter: combinational round-robin pick, searching upward from rr_ptr with wrap.
// Rev 1.0 - initial release.
`default_nettype none
`timescale 1ns/1ps

module uart_rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any_valid
);

    // Walk offsets from highest to lowest so the smallest offset from rr_ptr is written last.
    always_comb begin
        int              idx;
        logic [IDX_W-1:0] sel;
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
        sel       = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = IDX_W'(idx);
            if (req_valid[sel]) begin
                winner    = sel;
                any_valid = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: packet-level round-robin sharing of one 8N1 UART transmitter.
// Optional even parity (8E1) when UART_TX_PARITY_EN is defined. Rev 1.0 - initial release.
`default_nettype none
`timescale 1ns/1ps

module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = CLK_HZ / BAUD_RATE,
    parameter int GAP_TIMEOUT  = 4340
) (
    input  logic                           clk50,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           tx,
    output logic                           busy,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           lock_drop
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int GAP_W = (GAP_TIMEOUT > 1) ? $clog2(GAP_TIMEOUT) : 1;

    localparam logic [CNT_W-1:0] BIT_END = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [GAP_W-1:0] GAP_END = GAP_W'(GAP_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_ID = IDX_W'(NUM_REQ - 1);

    localparam logic [2:0] S_IDLE   = 3'(ST_IDLE);
    localparam logic [2:0] S_LOAD   = 3'(ST_LOAD);
    localparam logic [2:0] S_START  = 3'(ST_START);
    localparam logic [2:0] S_DATA   = 3'(ST_DATA);
    localparam logic [2:0] S_STOP   = 3'(ST_STOP);
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'(ST_PARITY);
`endif

    logic [2:0]             state;
    logic [IDX_W-1:0]       rr_ptr;
    logic [CNT_W-1:0]       clk_cnt;
    logic [2:0]             bit_idx;
    logic [UART_DATA_W-1:0] shift_reg;
    logic                   last_q;
    logic [GAP_W-1:0]       gap_cnt;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q;
`endif

    logic [IDX_W-1:0]       winner;
    logic                   any_valid;
    logic [UART_DATA_W-1:0] req_bytes [NUM_REQ];
    logic [UART_DATA_W-1:0] sel_byte;
    logic                   sel_valid;
    logic                   sel_last;
    logic                   bit_done;
    logic [IDX_W-1:0]       next_ptr;

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_unpack
            assign req_bytes[g] = req_data[UART_DATA_W*g +: UART_DATA_W];
        end
    endgenerate

    uart_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    assign sel_byte  = req_bytes[grant_id];
    assign sel_valid = req_valid[grant_id];
    assign sel_last  = req_last[grant_id];
    assign bit_done  = (clk_cnt == BIT_END);
    assign next_ptr  = (grant_id == LAST_ID) ? '0 : grant_id + IDX_W'(1);

    assign busy      = (state != S_IDLE);
    assign lock_drop = (state == S_LOAD) && !sel_valid && (gap_cnt == GAP_END);

    always_comb begin
        req_ready = '0;
        if (state == S_LOAD) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // tx is loaded together with the state change so each bit lands on the cycle its state begins.
    always_ff @(posedge clk50) begin
        if (reset) begin
            state     <= S_IDLE;
            tx        <= 1'b1;
            grant_id  <= '0;
            rr_ptr    <= '0;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            last_q    <= 1'b0;
            gap_cnt   <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (any_valid) begin
                        grant_id <= winner;
                        gap_cnt  <= '0;
                        clk_cnt  <= '0;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (sel_valid) begin
                        shift_reg <= sel_byte;
                        last_q    <= sel_last;
`ifdef UART_TX_PARITY_EN
                        parity_q  <= ^sel_byte;
`endif
                        gap_cnt   <= '0;
                        clk_cnt   <= '0;
                        tx        <= 1'b0;
                        state     <= S_START;
                    end else if (gap_cnt == GAP_END) begin
                        gap_cnt <= '0;
                        rr_ptr  <= next_ptr;
                        state   <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                S_START: begin
                    if (bit_done) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        tx      <= shift_reg[0];
                        state   <= S_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (bit_done) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= parity_q;
                            state <= S_PARITY;
`else
                            tx    <= 1'b1;
                            state <= S_STOP;
`endif
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            shift_reg <= {1'b0, shift_reg[UART_DATA_W-1:1]};
                            tx        <= shift_reg[1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_done) begin
                        clk_cnt <= '0;
                        tx      <= 1'b1;
                        state   <= S_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (bit_done) begin
                        clk_cnt <= '0;
                        if (last_q) begin
                            rr_ptr <= next_ptr;
                            state  <= S_IDLE;
                        end else begin
                            state  <= S_LOAD;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: scoreboard bench for uart_tx_scheduler (shortened bit period and gap timeout).
// Rev 1.0 - initial release.
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx_scheduler;

    localparam int NREQ = 4;
    localparam int C    = 16;
    localparam int GAP  = 160;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11 * C;
`else
    localparam int FRAME = 10 * C;
`endif

    logic        clk50 = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data  = '0;
    logic [3:0]  req_last  = '0;
    logic [3:0]  req_ready;
    logic        tx;
    logic        busy;
    logic [1:0]  grant_id;
    logic        lock_drop;

    uart_tx_scheduler #(
        .NUM_REQ      (NREQ),
        .CLKS_PER_BIT (C),
        .GAP_TIMEOUT  (GAP)
    ) dut (
        .clk50     (clk50),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx        (tx),
        .busy      (busy),
        .grant_id  (grant_id),
        .lock_drop (lock_drop)
    );

    always #5 clk50 = ~clk50;

    int cyc = 0;
    always @(posedge clk50) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         id;
        logic [7:0] data;
        logic       last;
    } pend_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] gid;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] gid;
        logic       start_bit;
        logic       stop_bit;
        logic       par;
        int         t_start;
    } rx_t;

    pend_t pend_q[$];
    exp_t  exp_q[$];
    rx_t   rx_q[$];
    int    drop_q[$];
    int    rise_cyc[4];

    // Requester model: presents the oldest pending byte per requester, advances on handshake.
    initial begin
        logic [3:0] hs;
        bit         found;
        forever begin
            @(negedge clk50);
            hs = reset ? 4'b0 : (req_valid & req_ready);
            @(posedge clk50);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (hs[i]) begin
                    for (int k = 0; k < pend_q.size(); k++) begin
                        if (pend_q[k].id == i) begin
                            pend_q.delete(k);
                            break;
                        end
                    end
                end
                found = 1'b0;
                for (int k = 0; k < pend_q.size(); k++) begin
                    if (!found && pend_q[k].id == i) begin
                        found = 1'b1;
                        if (!req_valid[i]) rise_cyc[i] = cyc;
                        req_valid[i]      = 1'b1;
                        req_data[8*i +: 8] = pend_q[k].data;
                        req_last[i]       = pend_q[k].last;
                    end
                end
                if (!found) begin
                    req_valid[i]      = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]       = 1'b0;
                end
            end
        end
    end

    task automatic mon_skip(input int n, inout bit ab);
        repeat (n) begin
            if (!ab) begin
                @(negedge clk50);
                if (reset) ab = 1'b1;
            end
        end
    endtask

    // Line monitor: decodes frames at mid-bit and records them with their start cycle.
    initial begin
        rx_t  r;
        bit   ab;
        logic prev;
        prev = 1'b1;
        forever begin
            @(negedge clk50);
            if (!reset && prev && !tx) begin
                ab        = 1'b0;
                r.t_start = cyc;
                r.gid     = grant_id;
                mon_skip(C / 2, ab);
                r.start_bit = tx;
                for (int b = 0; b < 8; b++) begin
                    mon_skip(C, ab);
                    r.data[b] = tx;
                end
`ifdef UART_TX_PARITY_EN
                mon_skip(C, ab);
                r.par = tx;
`else
                r.par = 1'b0;
`endif
                mon_skip(C, ab);
                r.stop_bit = tx;
                if (!ab) rx_q.push_back(r);
            end
            prev = tx;
        end
    end

    initial begin
        forever begin
            @(negedge clk50);
            if (lock_drop) drop_q.push_back(cyc);
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

    task automatic send(input int id, input logic [7:0] d, input logic last);
        pend_t p;
        exp_t  e;
        p.id = id; p.data = d; p.last = last;
        e.data = d; e.gid = 2'(id);
        pend_q.push_back(p);
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk50);
        reset = 1'b1;
        pend_q.delete();
        exp_q.delete();
        repeat (3) @(negedge clk50);
        rx_q.delete();
        drop_q.delete();
        reset = 1'b0;
        repeat (2) @(negedge clk50);
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        int t = 0;
        while (rx_q.size() < n && t < budget) begin
            @(negedge clk50);
            t++;
        end
        ok = (rx_q.size() >= n);
    endtask

    task automatic test_reset();
        @(negedge clk50);
        reset = 1'b1;
        repeat (2) @(negedge clk50);
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b expected 1", tx); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
        checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
        checks++; if (lock_drop !== 1'b0) begin failures++; $display("FAIL reset_lock_drop: got %b expected 0", lock_drop); end
        reset = 1'b0;
    endtask

    task automatic test_single_byte();
        bit   ok;
        rx_t  r;
        exp_t e;
        int   t;
        do_reset();
        send(0, 8'hA5, 1'b1);
        wait_rx(1, 3 * FRAME, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL single_timeout: got %0d frames expected 1", rx_q.size());
        end else begin
            r = rx_q.pop_front();
            e = exp_q.pop_front();
            checks++; if (r.data !== e.data) begin failures++; $display("FAIL single_data: got %h expected %h", r.data, e.data); end
            checks++; if (r.gid !== e.gid) begin failures++; $display("FAIL single_grant: got %0d expected %0d", r.gid, e.gid); end
            checks++; if (r.start_bit !== 1'b0 || r.stop_bit !== 1'b1) begin failures++; $display("FAIL single_framing: got start %b stop %b expected 0 1", r.start_bit, r.stop_bit); end
            checks++; if (r.t_start !== rise_cyc[0] + 2) begin failures++; $display("FAIL single_latency: got %0d expected %0d", r.t_start - rise_cyc[0], 2); end
            t = 0;
            while (busy && t < 2 * FRAME) begin @(negedge clk50); t++; end
            checks++; if (cyc !== r.t_start + FRAME) begin failures++; $display("FAIL single_busy_fall: got %0d expected %0d", cyc - r.t_start, FRAME); end
        end
        checks++; if (drop_q.size() !== 0) begin failures++; $display("FAIL single_no_drop: got %0d pulses expected 0", drop_q.size()); end
    endtask

    task automatic test_contention();
        bit   ok;
        rx_t  r;
        exp_t e;
        int   ts[4];
        do_reset();
        send(1, 8'h11, 1'b0);
        send(1, 8'h12, 1'b1);
        send(3, 8'h31, 1'b0);
        send(3, 8'h32, 1'b1);
        wait_rx(4, 6 * FRAME, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL contention_timeout: got %0d frames expected 4", rx_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                r = rx_q.pop_front();
                e = exp_q.pop_front();
                ts[k] = r.t_start;
                checks++;
                if (r.data !== e.data || r.gid !== e.gid) begin
                    failures++; $display("FAIL contention_order[%0d]: got id %0d data %h expected id %0d data %h", k, r.gid, r.data, e.gid, e.data);
                end
            end
            checks++; if (ts[1] - ts[0] !== FRAME + 1) begin failures++; $display("FAIL contention_b2b: got %0d expected %0d", ts[1] - ts[0], FRAME + 1); end
            checks++; if (ts[2] - ts[1] !== FRAME + 2) begin failures++; $display("FAIL contention_pkt_gap: got %0d expected %0d", ts[2] - ts[1], FRAME + 2); end
        end
    endtask

    task automatic test_fairness();
        bit   ok;
        rx_t  r;
        exp_t e;
        logic [1:0] prev_gid;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                send(i, 8'(8'h40 + k * NREQ + i), 1'b1);
            end
        end
        wait_rx(8, 10 * FRAME, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL fairness_timeout: got %0d frames expected 8", rx_q.size());
        end else begin
            prev_gid = 2'd3;
            for (int k = 0; k < 8; k++) begin
                r = rx_q.pop_front();
                e = exp_q.pop_front();
                checks++;
                if (r.data !== e.data || r.gid !== e.gid || r.gid === prev_gid) begin
                    failures++; $display("FAIL fairness_order[%0d]: got id %0d data %h expected id %0d data %h", k, r.gid, r.data, e.gid, e.data);
                end
                prev_gid = r.gid;
            end
        end
    endtask

    task automatic test_gap_timeout();
        bit   ok;
        rx_t  r;
        exp_t e;
        int   t0;
        do_reset();
        send(2, 8'h2A, 1'b0);
        wait_rx(1, 3 * FRAME, ok);
        send(3, 8'h33, 1'b1);
        send(0, 8'h03, 1'b1);
        wait_rx(3, 4 * FRAME + GAP, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL gap_timeout_frames: got %0d frames expected 3", rx_q.size());
        end else begin
            r = rx_q.pop_front(); e = exp_q.pop_front();
            t0 = r.t_start;
            checks++; if (r.data !== e.data || r.gid !== e.gid) begin failures++; $display("FAIL gap_first: got id %0d data %h expected id %0d data %h", r.gid, r.data, e.gid, e.data); end
            checks++; if (drop_q.size() !== 1) begin failures++; $display("FAIL gap_drop_count: got %0d expected 1", drop_q.size()); end
            else begin
                checks++; if (drop_q[0] !== t0 + FRAME + GAP - 1) begin failures++; $display("FAIL gap_drop_time: got %0d expected %0d", drop_q[0] - t0, FRAME + GAP - 1); end
            end
            r = rx_q.pop_front(); e = exp_q.pop_front();
            checks++; if (r.data !== e.data || r.gid !== e.gid) begin failures++; $display("FAIL gap_next_req3: got id %0d data %h expected id %0d data %h", r.gid, r.data, e.gid, e.data); end
            checks++; if (r.t_start !== t0 + FRAME + GAP + 2) begin failures++; $display("FAIL gap_next_start: got %0d expected %0d", r.t_start - t0, FRAME + GAP + 2); end
            r = rx_q.pop_front(); e = exp_q.pop_front();
            checks++; if (r.data !== e.data || r.gid !== e.gid) begin failures++; $display("FAIL gap_then_req0: got id %0d data %h expected id %0d data %h", r.gid, r.data, e.gid, e.data); end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit   ok;
        rx_t  r;
        exp_t e;
        int   t_s;
        int   t;
        do_reset();
        send(2, 8'h5A, 1'b1);
        t = 0;
        while (tx !== 1'b0 && t < 4 * C) begin @(negedge clk50); t++; end
        t_s = cyc;
        checks++;
        if (tx !== 1'b0) begin
            failures++; $display("FAIL midreset_start: got tx %b expected 0", tx);
        end else begin
            while (cyc < t_s + 5 * C + C / 2) @(negedge clk50);
            reset = 1'b1;
            @(posedge clk50);
            #1;
            checks++; if (tx !== 1'b1) begin failures++; $display("FAIL midreset_tx: got %b expected 1", tx); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b expected 0", busy); end
            checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL midreset_ready: got %b expected 0000", req_ready); end
            checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL midreset_grant: got %0d expected 0", grant_id); end
            repeat (2) @(negedge clk50);
            reset = 1'b0;
        end
        exp_q.delete();
        repeat (3) @(negedge clk50);
        send(1, 8'h3C, 1'b1);
        wait_rx(1, 3 * FRAME, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL midreset_recover_timeout: got %0d frames expected 1", rx_q.size());
        end else begin
            r = rx_q.pop_front(); e = exp_q.pop_front();
            checks++; if (r.data !== e.data || r.gid !== e.gid || r.stop_bit !== 1'b1) begin failures++; $display("FAIL midreset_recover: got id %0d data %h stop %b expected id %0d data %h stop 1", r.gid, r.data, r.stop_bit, e.gid, e.data); end
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        bit   ok;
        rx_t  r0;
        rx_t  r1;
        do_reset();
        send(0, 8'h07, 1'b1);
        send(1, 8'h03, 1'b1);
        wait_rx(2, 4 * FRAME, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL parity_timeout: got %0d frames expected 2", rx_q.size());
        end else begin
            r0 = rx_q.pop_front();
            r1 = rx_q.pop_front();
            checks++; if (r0.data !== 8'h07 || r0.par !== 1'b1) begin failures++; $display("FAIL parity_07: got data %h par %b expected 07 1", r0.data, r0.par); end
            checks++; if (r1.data !== 8'h03 || r1.par !== 1'b0) begin failures++; $display("FAIL parity_03: got data %h par %b expected 03 0", r1.data, r1.par); end
            checks++; if (r1.t_start - r0.t_start !== 11 * C + 2) begin failures++; $display("FAIL parity_frame_len: got %0d expected %0d", r1.t_start - r0.t_start, 11 * C + 2); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_byte();
        test_contention();
        test_fairness();
        test_gap_timeout();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
